// File: rtl/mux_n1_pipe.sv
// mux_n1_pipe: parametrised N:1 operand select feeding a 1..4 stage register
// pipeline with valid tracking, stall and flush.
// Optional sticky out-of-range select flag: define MUX_N1_PIPE_SEL_ERR_EN.
// Without the macro err_o is tied low and no detection logic exists.
module mux_n1_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned N_IN   = 3,
  parameter int unsigned STAGES = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_IN*WIDTH-1:0]     d_i,
  input  logic [$clog2(N_IN)-1:0]   s_i,
  input  logic                      valid_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic [WIDTH-1:0]          y_o,
  output logic                      valid_o,
  output logic [$clog2(N_IN)-1:0]   sel_o,
  output logic                      err_o
);

  localparam int unsigned SEL_W = $clog2(N_IN);
  localparam int unsigned LAST  = STAGES - 1;

  logic [WIDTH-1:0] d_arr [N_IN];
  logic [SEL_W:0]   s_ext_c;
  logic             s_oor_c;
  logic [SEL_W-1:0] sel_eff_c;
  logic [WIDTH-1:0] data_sel_c;

  logic [WIDTH-1:0] data_q  [STAGES];
  logic [SEL_W-1:0] sel_q   [STAGES];
  logic [STAGES-1:0] valid_q;

  // Unpack the flat data bus into one word per input.
  always_comb begin
    for (int unsigned k = 0; k < N_IN; k++) begin
      d_arr[k] = d_i[k*WIDTH +: WIDTH];
    end
  end

  // Saturate out-of-range selects to the highest input, then pick the word.
  always_comb begin
    s_ext_c    = {1'b0, s_i};
    s_oor_c    = (s_ext_c >= (SEL_W+1)'(N_IN));
    sel_eff_c  = s_oor_c ? SEL_W'(N_IN - 1) : s_i;
    data_sel_c = d_arr[sel_eff_c];
  end

  // Pipeline: flush clears valids only, stall freezes, otherwise advance.
  // Stage 0 data/sel only load on a valid word to avoid needless toggling.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        sel_q[i]  <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (!stall_i) begin
      for (int unsigned i = 1; i < STAGES; i++) begin
        data_q[i]  <= data_q[i-1];
        sel_q[i]   <= sel_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
      valid_q[0] <= valid_i;
      if (valid_i) begin
        data_q[0] <= data_sel_c;
        sel_q[0]  <= sel_eff_c;
      end
    end
  end

  assign y_o     = data_q[LAST];
  assign valid_o = valid_q[LAST];
  assign sel_o   = sel_q[LAST];

`ifdef MUX_N1_PIPE_SEL_ERR_EN
  logic err_q;

  // Sticky flag for any accepted word whose select was out of range.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (valid_i && !stall_i && !flush_i && s_oor_c) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n1_pipe.sv
// Directed bench for mux_n1_pipe: four instances cover STAGES=1/2/3 with
// N_IN=3, WIDTH=32 and a randomised N_IN=16, WIDTH=8, STAGES=4 sweep.
module tb_mux_n1_pipe;

`ifdef MUX_N1_PIPE_SEL_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // dut_a: 3:1, 32-bit, 1 stage
  logic [95:0] a_d;
  logic [1:0]  a_s, a_so;
  logic        a_v, a_st, a_fl, a_vo, a_err;
  logic [31:0] a_y;
  // dut_b: 3:1, 32-bit, 3 stages
  logic [95:0] b_d;
  logic [1:0]  b_s, b_so;
  logic        b_v, b_st, b_fl, b_vo, b_err;
  logic [31:0] b_y;
  // dut_c: 3:1, 32-bit, 2 stages
  logic [95:0] c_d;
  logic [1:0]  c_s, c_so;
  logic        c_v, c_st, c_fl, c_vo, c_err;
  logic [31:0] c_y;
  // dut_d: 16:1, 8-bit, 4 stages
  logic [127:0] d_d;
  logic [3:0]   d_s, d_so;
  logic         d_v, d_st, d_fl, d_vo, d_err;
  logic [7:0]   d_y;

  mux_n1_pipe #(.WIDTH(32), .N_IN(3), .STAGES(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .d_i(a_d), .s_i(a_s), .valid_i(a_v),
    .stall_i(a_st), .flush_i(a_fl), .y_o(a_y), .valid_o(a_vo),
    .sel_o(a_so), .err_o(a_err));

  mux_n1_pipe #(.WIDTH(32), .N_IN(3), .STAGES(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .d_i(b_d), .s_i(b_s), .valid_i(b_v),
    .stall_i(b_st), .flush_i(b_fl), .y_o(b_y), .valid_o(b_vo),
    .sel_o(b_so), .err_o(b_err));

  mux_n1_pipe #(.WIDTH(32), .N_IN(3), .STAGES(2)) dut_c (
    .clk_i(clk), .rst_i(rst), .d_i(c_d), .s_i(c_s), .valid_i(c_v),
    .stall_i(c_st), .flush_i(c_fl), .y_o(c_y), .valid_o(c_vo),
    .sel_o(c_so), .err_o(c_err));

  mux_n1_pipe #(.WIDTH(8), .N_IN(16), .STAGES(4)) dut_d (
    .clk_i(clk), .rst_i(rst), .d_i(d_d), .s_i(d_s), .valid_i(d_v),
    .stall_i(d_st), .flush_i(d_fl), .y_o(d_y), .valid_o(d_vo),
    .sel_o(d_so), .err_o(d_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_d = {32'h33333333, 32'h22222222, 32'h11111111};
    a_s = 2'd0;
    a_v = 1'b1;
    tick();
    total++;
    if ({a_y, a_vo, a_so} !== {32'h11111111, 1'b1, 2'd0}) begin
      bad++;
      $display("FAIL pre_reset_word got y=%h v=%b sel=%0d want y=11111111 v=1 sel=0", a_y, a_vo, a_so);
    end
    a_s = 2'd2;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({a_y, a_vo, a_so, a_err} !== {32'h0, 1'b0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got y=%h v=%b sel=%0d err=%b want all 0", a_y, a_vo, a_so, a_err);
    end
    tick();
    total++;
    if ({a_y, a_vo, a_so, a_err} !== {32'h0, 1'b0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL held_reset got y=%h v=%b sel=%0d err=%b want all 0", a_y, a_vo, a_so, a_err);
    end
    total++;
    if ({b_vo, c_vo, d_vo, b_y, c_y, d_y} !== '0) begin
      bad++;
      $display("FAIL reset_others got bv=%b cv=%b dv=%b by=%h cy=%h dy=%h want 0", b_vo, c_vo, d_vo, b_y, c_y, d_y);
    end
    a_v = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic_select();
    logic [31:0] exp_y [3];
    exp_y[0] = 32'h11111111;
    exp_y[1] = 32'h22222222;
    exp_y[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      a_s = 2'(i);
      a_v = 1'b1;
      tick();
      total++;
      if ({a_y, a_vo, a_so} !== {exp_y[i], 1'b1, 2'(i)}) begin
        bad++;
        $display("FAIL select_%0d got y=%h v=%b sel=%0d want y=%h v=1 sel=%0d", i, a_y, a_vo, a_so, exp_y[i], i);
      end
    end
    a_v = 1'b0;
    tick();
    total++;
    if ({a_y, a_vo, a_so, a_err} !== {32'h33333333, 1'b0, 2'd2, 1'b0}) begin
      bad++;
      $display("FAIL select_idle got y=%h v=%b sel=%0d err=%b want y=33333333 v=0 sel=2 err=0", a_y, a_vo, a_so, a_err);
    end
  endtask

  task automatic test_out_of_range();
    a_d = {32'h33333333, 32'h22222222, 32'h11111111};
    a_s = 2'd3;
    a_v = 1'b1;
    tick();
    total++;
    if ({a_y, a_vo, a_so, a_err} !== {32'h33333333, 1'b1, 2'd2, ERR_EXP}) begin
      bad++;
      $display("FAIL oor_sel got y=%h v=%b sel=%0d err=%b want y=33333333 v=1 sel=2 err=%b", a_y, a_vo, a_so, a_err, ERR_EXP);
    end
    a_v = 1'b0;
    a_s = 2'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (a_err !== ERR_EXP) begin
        bad++;
        $display("FAIL err_sticky_%0d got err=%b want %b", i, a_err, ERR_EXP);
      end
    end
  endtask

  task automatic test_hold_invalid();
    a_d[31:0] = 32'hDEADBEEF;
    a_s = 2'd0;
    a_v = 1'b1;
    tick();
    total++;
    if ({a_y, a_vo, a_so} !== {32'hDEADBEEF, 1'b1, 2'd0}) begin
      bad++;
      $display("FAIL hold_capture got y=%h v=%b sel=%0d want y=deadbeef v=1 sel=0", a_y, a_vo, a_so);
    end
    a_v = 1'b0;
    a_d[31:0] = 32'h12345678;
    a_s = 2'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({a_y, a_vo, a_so} !== {32'hDEADBEEF, 1'b0, 2'd0}) begin
        bad++;
        $display("FAIL hold_idle_%0d got y=%h v=%b sel=%0d want y=deadbeef v=0 sel=0", i, a_y, a_vo, a_so);
      end
    end
  endtask

  task automatic test_stall();
    localparam logic [31:0] WA = 32'hAAAA0001;
    localparam logic [31:0] WB = 32'hBBBB0002;
    localparam logic [31:0] WC = 32'hCCCC0003;
    logic        st  [11] = '{0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0};
    logic        vin [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [1:0]  sin [11] = '{0, 1, 2, 2, 2, 0, 0, 0, 0, 0, 0};
    logic        ev  [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    logic [31:0] ey  [11] = '{0, 0, 0, 0, WA, WA, WA, WB, WC, WC, WC};
    logic [1:0]  es  [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 2};
    b_d = {WC, WB, WA};
    for (int i = 0; i < 11; i++) begin
      if (i == 5) b_d[31:0] = 32'h99999999;
      b_st = st[i];
      b_v  = vin[i];
      b_s  = sin[i];
      tick();
      total++;
      if ({b_y, b_vo, b_so} !== {ey[i], ev[i], es[i]}) begin
        bad++;
        $display("FAIL stall_step%0d got y=%h v=%b sel=%0d want y=%h v=%b sel=%0d", i, b_y, b_vo, b_so, ey[i], ev[i], es[i]);
      end
    end
    b_st = 1'b0;
    b_v  = 1'b0;
  endtask

  task automatic test_flush();
    localparam logic [31:0] WA = 32'hA0A0A0A0;
    localparam logic [31:0] WB = 32'hB0B0B0B0;
    localparam logic [31:0] WC = 32'hC0C0C0C0;
    localparam logic [31:0] WD = 32'hD0D0D0D0;
    logic        fl  [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    logic        st  [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    logic        vin [8] = '{1, 1, 1, 0, 0, 1, 0, 0};
    logic [1:0]  sin [8] = '{0, 1, 2, 0, 0, 0, 0, 0};
    logic        ev  [8] = '{0, 1, 0, 0, 0, 0, 1, 0};
    logic [31:0] ey  [8] = '{0, WA, WA, WB, WB, WB, WD, WD};
    logic [1:0]  es  [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    c_d = {WC, WB, WA};
    for (int i = 0; i < 8; i++) begin
      if (i == 5) c_d[31:0] = WD;
      c_fl = fl[i];
      c_st = st[i];
      c_v  = vin[i];
      c_s  = sin[i];
      tick();
      total++;
      if ({c_y, c_vo, c_so} !== {ey[i], ev[i], es[i]}) begin
        bad++;
        $display("FAIL flush_step%0d got y=%h v=%b sel=%0d want y=%h v=%b sel=%0d", i, c_y, c_vo, c_so, ey[i], ev[i], es[i]);
      end
    end
    c_v = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] sel;
    logic       v;
  } ent_t;

  task automatic test_sweep();
    ent_t q[$];
    ent_t ne;
    ent_t exp_e;
    int   errs;
    errs = 0;
    for (int i = 0; i < 4; i++) q.push_back('0);
    for (int n = 0; n < 10000; n++) begin
      d_d  = {$urandom(), $urandom(), $urandom(), $urandom()};
      d_s  = 4'($urandom_range(0, 15));
      d_v  = ($urandom_range(0, 3) != 0);
      d_st = ($urandom_range(0, 7) == 0);
      d_fl = ($urandom_range(0, 15) == 0);
      tick();
      if (d_fl) begin
        foreach (q[k]) q[k].v = 1'b0;
      end else if (!d_st) begin
        if (d_v) ne = '{data: d_d[d_s*8 +: 8], sel: d_s, v: 1'b1};
        else     ne = '{data: q[0].data, sel: q[0].sel, v: 1'b0};
        q.push_front(ne);
        void'(q.pop_back());
      end
      exp_e = q[3];
      total++;
      if ({d_y, d_so, d_vo} !== {exp_e.data, exp_e.sel, exp_e.v}) begin
        bad++;
        errs++;
        if (errs <= 20)
          $display("FAIL sweep_cyc%0d got y=%h sel=%0d v=%b want y=%h sel=%0d v=%b", n, d_y, d_so, d_vo, exp_e.data, exp_e.sel, exp_e.v);
      end
    end
    total++;
    if (d_err !== 1'b0) begin
      bad++;
      $display("FAIL sweep_err got err=%b want 0", d_err);
    end
    d_v  = 1'b0;
    d_st = 1'b0;
    d_fl = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a_d = '0; a_s = '0; a_v = 1'b0; a_st = 1'b0; a_fl = 1'b0;
    b_d = '0; b_s = '0; b_v = 1'b0; b_st = 1'b0; b_fl = 1'b0;
    c_d = '0; c_s = '0; c_v = 1'b0; c_st = 1'b0; c_fl = 1'b0;
    d_d = '0; d_s = '0; d_v = 1'b0; d_st = 1'b0; d_fl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic_select();
    test_out_of_range();
    test_hold_invalid();
    test_stall();
    test_flush();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_n1_pipe.md
Name: mux_n1_pipe

Overview:
- Parametrised N:1 selector with a configurable registered output pipeline, valid tracking, stall and flush.
- Used in the datapath wherever a pipelined, hazard-controlled operand select is needed (ALU operand forwarding, writeback-source select).
- Generalises the 3:1 32-bit combinational mux:
  - arbitrary width and input count;
  - 1..4 register stages;
  - stall/flush control;
  - optional select-error detection.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_IN, 3, number of data inputs; legal range 2..16.
- STAGES, 1, number of output register stages (latency in cycles); legal range 1..4.
- SEL_W is a derived localparam, not overridable: $clog2(N_IN).

Ports:
- clk_i  input  1  clock; all registers rising-edge.
- rst_i  input  1  reset; asynchronous, active-high.
- d_i  input  N_IN*WIDTH  packed data inputs; input k occupies bits [k*WIDTH +: WIDTH].
- s_i  input  SEL_W  binary select.
- valid_i  input  1  the select/data on this cycle are meaningful.
- stall_i  input  1  freeze the whole pipeline.
- flush_i  input  1  invalidate all stages.
- y_o  output  WIDTH  selected data, STAGES cycles after capture.
- valid_o  output  1  y_o is valid.
- sel_o  output  SEL_W  effective select that produced y_o.
- err_o  output  1  sticky out-of-range-select flag; active only with the optional feature.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high on rst_i.
  - While rst_i=1, every stage register (data, valid, sel) and err_o are 0.
  - Hence y_o=0, valid_o=0, sel_o=0.
  - The first capture occurs on the first rising edge after rst_i deasserts.
- Effective select:
  - sel_eff = s_i when s_i < N_IN, else N_IN-1.
  - Out-of-range values saturate to the highest input. This matches the legacy 3:1 behaviour, where s=3 selects input 2.
  - Selection is combinational into stage 0 only; no combinational path from d_i or s_i to any output.
- Pipeline: stages 0..STAGES-1, each holding {data, valid, sel}. Outputs are driven from stage STAGES-1.
- Per-edge update priority, highest first:
  1. flush_i=1: all valid bits cleared to 0; data and sel registers hold their value. flush overrides stall.
  2. stall_i=1 (no flush): all stages hold every field.
  3. Otherwise the pipeline advances:
     - stage i takes stage i-1;
     - stage 0 takes valid=valid_i;
     - when valid_i=1, stage 0 also takes data=d_i[sel_eff] and sel=sel_eff;
     - when valid_i=0, stage 0 data and sel hold their previous value. This is a toggle-reduction rule that the bench checks.
- Latency: a valid word captured at edge t appears on y_o/valid_o after edge t+STAGES-1, i.e. visible for the cycle following that edge. Every stall cycle adds one cycle.
- Simultaneous events:
  - valid_i=1 with flush_i=1: the incoming word is dropped.
  - valid_i=1 with stall_i=1: the incoming word is dropped. The upstream hazard unit must hold it.
- Reset mid-operation: immediate asynchronous clear of all state, including in-flight words; no partial outputs.
- Throughput: one word per cycle when not stalled; no bubbles inserted by the block.

Optional Feature:
- Macro: MUX_N1_PIPE_SEL_ERR_EN.
- Defined:
  - err_o sets to 1 on any edge where valid_i=1, stall_i=0, flush_i=0 and s_i >= N_IN.
  - Sticky; cleared only by rst_i.
  - Saturation to N_IN-1 still applies.
- Not defined:
  - No detection logic is synthesised.
  - err_o is tied to 0.
  - Datapath behaviour is otherwise identical.

Test Plan:
1. Reset and basic select: WIDTH=32, N_IN=3, STAGES=1; d0=0x11111111, d1=0x22222222, d2=0x33333333; assert rst_i mid-cycle, then release. Expect all outputs 0 during reset. Then valid_i=1 with s_i=0,1,2 on consecutive cycles: y_o=0x11111111, 0x22222222, 0x33333333 one cycle later each, valid_o=1, sel_o=0,1,2.
2. Out-of-range select: N_IN=3, s_i=3, valid_i=1. Expect y_o=d2, sel_o=2. err_o=1 with the macro defined and stays 1 for 10 further cycles; err_o=0 without the macro.
3. Stall: STAGES=3, stream words A,B,C, assert stall_i for 2 cycles after B is captured. Expect y_o/valid_o frozen for those 2 cycles, no word lost or duplicated, and A,B,C emerge in order with latency 3+2 for B and C.
4. Flush priority: STAGES=2 with 2 words in flight; assert flush_i=1 and stall_i=1 in the same cycle with valid_i=1. Expect valid_o=0 for the next 2 cycles and no dropped word ever appearing.
5. Hold on invalid: capture 0xDEADBEEF with valid_i=1, then valid_i=0 with d_i changed. Expect y_o stays 0xDEADBEEF, valid_o=0, sel_o unchanged.
6. Parameter sweep: N_IN=16, WIDTH=8, STAGES=4, random s_i/d_i with random stall_i and flush_i, checked against a reference queue model. Expect zero mismatches over 10,000 cycles.
